// File: rtl/mmio_io_ctrl.sv
// Memory-mapped I/O controller for the board peripherals.
// Decodes the processor's data-memory port into HEX/LEDR/LEDG output
// registers, debounced KEY/SW inputs and a sticky key-press status register.
// Reads are registered and return one cycle after rdEn.
module mmio_io_ctrl #(
  parameter int unsigned       DBITS      = 32,
  parameter logic [DBITS-1:0]  BASE_ADDR  = DBITS'(32'hF0000000),
  parameter int unsigned       HEX_DIGITS = 4,
  parameter int unsigned       LEDR_BITS  = 10,
  parameter int unsigned       LEDG_BITS  = 8,
  parameter int unsigned       KEY_BITS   = 4,
  parameter int unsigned       SW_BITS    = 10,
  parameter logic [15:0]       DEB_CYCLES = 16'd50000
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [DBITS-1:0]        addr,
  input  logic                    wrEn,
  input  logic [DBITS-1:0]        wrData,
  input  logic                    rdEn,
  output logic [DBITS-1:0]        rdData,
  output logic                    rdValid,
  output logic                    sel,
  input  logic [KEY_BITS-1:0]     KEY,
  input  logic [SW_BITS-1:0]      SW,
  output logic [7*HEX_DIGITS-1:0] HEX,
  output logic [LEDR_BITS-1:0]    LEDR,
  output logic [LEDG_BITS-1:0]    LEDG
);

  localparam int HEX_W = 4 * HEX_DIGITS;
  // Keys occupy the low bits of the shared input vector, switches the high bits.
  localparam int NIN   = KEY_BITS + SW_BITS;
  localparam int CW    = (DEB_CYCLES > 16'd1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 16'd1);

  localparam logic [DBITS-1:0] A_HEX   = BASE_ADDR;
  localparam logic [DBITS-1:0] A_LEDR  = BASE_ADDR + DBITS'(32'h04);
  localparam logic [DBITS-1:0] A_LEDG  = BASE_ADDR + DBITS'(32'h08);
  localparam logic [DBITS-1:0] A_KEY   = BASE_ADDR + DBITS'(32'h10);
  localparam logic [DBITS-1:0] A_SW    = BASE_ADDR + DBITS'(32'h14);
  localparam logic [DBITS-1:0] A_KSTAT = BASE_ADDR + DBITS'(32'h18);

  // Active-low 7-segment glyphs, bit order gfedcba.
  function automatic logic [6:0] seg7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  logic w_hit_hex, w_hit_ledr, w_hit_ledg, w_hit_key, w_hit_sw, w_hit_kstat;
  logic [HEX_W-1:0]     r_hex;
  logic [LEDR_BITS-1:0] r_ledr;
  logic [LEDG_BITS-1:0] r_ledg;
  logic [KEY_BITS-1:0]  r_kstat;
  logic [NIN-1:0]       w_raw, r_sync1, r_sync2, r_stable, w_upd;
  logic [CW-1:0]        r_cnt [NIN];
  logic [KEY_BITS-1:0]  w_key_rise, w_kclr;
  logic [DBITS-1:0]     w_rd_mux, r_rdData;
  logic                 r_rdValid;
  logic                 w_unused;

  assign w_hit_hex   = (addr == A_HEX);
  assign w_hit_ledr  = (addr == A_LEDR);
  assign w_hit_ledg  = (addr == A_LEDG);
  assign w_hit_key   = (addr == A_KEY);
  assign w_hit_sw    = (addr == A_SW);
  assign w_hit_kstat = (addr == A_KSTAT);
  assign sel = w_hit_hex | w_hit_ledr | w_hit_ledg | w_hit_key | w_hit_sw | w_hit_kstat;

  // Only the low register-width bits of the write data are meaningful.
  assign w_unused = ^wrData;

  // Keys are inverted before synchronising so that 1 means pressed.
  assign w_raw = {SW, ~KEY};

  // Two-flop synchroniser for every asynchronous input bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

  // A bit updates when it has disagreed with the stable value for DEB_CYCLES cycles.
  always_comb begin
    w_upd = '0;
    for (int i = 0; i < NIN; i++)
      w_upd[i] = (r_sync2[i] != r_stable[i]) && (r_cnt[i] == CNT_MAX);
  end

  // Debounce counters and stable levels; the counter clears on agreement or on update.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stable <= '0;
      for (int i = 0; i < NIN; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NIN; i++) begin
        if (r_sync2[i] == r_stable[i]) begin
          r_cnt[i] <= '0;
        end else if (w_upd[i]) begin
          r_stable[i] <= r_sync2[i];
          r_cnt[i]    <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CW'(1);
        end
      end
    end
  end

  // A key press edge is an update whose new value is 1 (stable was 0).
  assign w_key_rise = w_upd[KEY_BITS-1:0] & r_sync2[KEY_BITS-1:0];
  assign w_kclr     = (wrEn && w_hit_kstat) ? wrData[KEY_BITS-1:0] : '0;

  // Writable registers; a new press overrides a simultaneous write-1-to-clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hex   <= '0;
      r_ledr  <= '0;
      r_ledg  <= '0;
      r_kstat <= '0;
    end else begin
      if (wrEn && w_hit_hex)  r_hex  <= wrData[HEX_W-1:0];
      if (wrEn && w_hit_ledr) r_ledr <= wrData[LEDR_BITS-1:0];
      if (wrEn && w_hit_ledg) r_ledg <= wrData[LEDG_BITS-1:0];
      r_kstat <= (r_kstat & ~w_kclr) | w_key_rise;
    end
  end

  // Read source selection; unmapped addresses read as zero.
  always_comb begin
    w_rd_mux = '0;
    if (w_hit_hex)   w_rd_mux = DBITS'(r_hex);
    if (w_hit_ledr)  w_rd_mux = DBITS'(r_ledr);
    if (w_hit_ledg)  w_rd_mux = DBITS'(r_ledg);
    if (w_hit_key)   w_rd_mux = DBITS'(r_stable[KEY_BITS-1:0]);
    if (w_hit_sw)    w_rd_mux = DBITS'(r_stable[NIN-1:KEY_BITS]);
    if (w_hit_kstat) w_rd_mux = DBITS'(r_kstat);
  end

  // Registered read port: samples pre-write register values, one result per rdEn.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rdData  <= '0;
      r_rdValid <= 1'b0;
    end else begin
      r_rdValid <= rdEn;
      if (rdEn) r_rdData <= w_rd_mux;
    end
  end

  assign rdData  = r_rdData;
  assign rdValid = r_rdValid;
  assign LEDR    = r_ledr;
  assign LEDG    = r_ledg;

  // Per-digit hex decode of the HEX register.
  always_comb begin
    HEX = '1;
    for (int i = 0; i < HEX_DIGITS; i++)
      HEX[7*i +: 7] = seg7(r_hex[4*i +: 4]);
  end

endmodule

// File: tb/tb_mmio_io_ctrl.sv
// Bench for mmio_io_ctrl with an 8-cycle debounce window.
module tb_mmio_io_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] addr = '0, wrData = '0, rdData;
  logic        wrEn = 1'b0, rdEn = 1'b0, rdValid, sel;
  logic [3:0]  KEY = 4'hF;
  logic [9:0]  SW = '0;
  logic [27:0] HEX;
  logic [9:0]  LEDR;
  logic [7:0]  LEDG;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [31:0] B      = 32'hF0000000;
  localparam logic [31:0] A_HEX  = B;
  localparam logic [31:0] A_LEDR = B + 32'h04;
  localparam logic [31:0] A_LEDG = B + 32'h08;
  localparam logic [31:0] A_KEY  = B + 32'h10;
  localparam logic [31:0] A_SW   = B + 32'h14;
  localparam logic [31:0] A_KST  = B + 32'h18;

  localparam logic [27:0] H_RST  = {4{7'b1000000}};
  // digits 3..0 = A,1,F,0
  localparam logic [27:0] H_A1F0 = {7'b0001000, 7'b1111001, 7'b0001110, 7'b1000000};
  localparam logic [27:0] H_FFFF = {4{7'b0001110}};
  // digits 3..0 = 6,E,2,d
  localparam logic [27:0] H_6E2D = {7'b0000010, 7'b0000110, 7'b0100100, 7'b0100001};
  // digits 3..0 = 8,b,7,4
  localparam logic [27:0] H_8B74 = {7'b0000000, 7'b0000011, 7'b1111000, 7'b0011001};

  mmio_io_ctrl #(.DEB_CYCLES(16'd8)) dut (
    .clk(clk), .reset_n(reset_n), .addr(addr), .wrEn(wrEn), .wrData(wrData),
    .rdEn(rdEn), .rdData(rdData), .rdValid(rdValid), .sel(sel),
    .KEY(KEY), .SW(SW), .HEX(HEX), .LEDR(LEDR), .LEDG(LEDG)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, output logic s);
    @(negedge clk);
    addr = a; wrData = d; wrEn = 1'b1;
    #1 s = sel;
    @(negedge clk);
    wrEn = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d, output logic v, output logic s);
    @(negedge clk);
    addr = a; rdEn = 1'b1;
    #1 s = sel;
    @(posedge clk);
    #1 d = rdData; v = rdValid;
    rdEn = 1'b0;
  endtask

  task automatic rd_chk(input string nm, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    logic v, s;
    rd(a, d, v, s);
    chk({nm, " data"}, d, exp);
    chk({nm, " valid"}, {31'b0, v}, 32'h1);
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] rd;
    bit          s;
    logic [27:0] hex;
    logic [9:0]  ledr;
    logic [7:0]  ledg;
  } vec_t;

  localparam int NV = 20;
  vec_t vt [NV];

  initial begin
    logic [31:0] d;
    logic v, s;
    int lat;

    vt[0]  = '{0, A_HEX,       32'h0,        32'h0,        1, H_RST,  10'h0,   8'h0};
    vt[1]  = '{0, A_LEDR,      32'h0,        32'h0,        1, H_RST,  10'h0,   8'h0};
    vt[2]  = '{0, A_LEDG,      32'h0,        32'h0,        1, H_RST,  10'h0,   8'h0};
    vt[3]  = '{0, A_KST,       32'h0,        32'h0,        1, H_RST,  10'h0,   8'h0};
    vt[4]  = '{0, A_KEY,       32'h0,        32'h0,        1, H_RST,  10'h0,   8'h0};
    vt[5]  = '{0, A_SW,        32'h0,        32'h0,        1, H_RST,  10'h0,   8'h0};
    vt[6]  = '{1, A_HEX,       32'h0000A1F0, 32'h0,        1, H_A1F0, 10'h0,   8'h0};
    vt[7]  = '{0, A_HEX,       32'h0,        32'h0000A1F0, 1, H_A1F0, 10'h0,   8'h0};
    vt[8]  = '{1, A_LEDR,      32'hFFFFFFFF, 32'h0,        1, H_A1F0, 10'h3FF, 8'h0};
    vt[9]  = '{0, A_LEDR,      32'h0,        32'h000003FF, 1, H_A1F0, 10'h3FF, 8'h0};
    vt[10] = '{1, A_LEDG,      32'h12345678, 32'h0,        1, H_A1F0, 10'h3FF, 8'h78};
    vt[11] = '{0, A_LEDG,      32'h0,        32'h00000078, 1, H_A1F0, 10'h3FF, 8'h78};
    vt[12] = '{0, B + 32'hC,   32'h0,        32'h0,        0, H_A1F0, 10'h3FF, 8'h78};
    vt[13] = '{0, B + 32'h2,   32'h0,        32'h0,        0, H_A1F0, 10'h3FF, 8'h78};
    vt[14] = '{0, 32'h10,      32'h0,        32'h0,        0, H_A1F0, 10'h3FF, 8'h78};
    vt[15] = '{1, B + 32'hC,   32'hFFFFFFFF, 32'h0,        0, H_A1F0, 10'h3FF, 8'h78};
    vt[16] = '{1, A_HEX,       32'hFFFFFFFF, 32'h0,        1, H_FFFF, 10'h3FF, 8'h78};
    vt[17] = '{0, A_HEX,       32'h0,        32'h0000FFFF, 1, H_FFFF, 10'h3FF, 8'h78};
    vt[18] = '{1, A_HEX,       32'h00006E2D, 32'h0,        1, H_6E2D, 10'h3FF, 8'h78};
    vt[19] = '{1, A_HEX,       32'h00008B74, 32'h0,        1, H_8B74, 10'h3FF, 8'h78};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst HEX", {4'b0, HEX}, {4'b0, H_RST});
    chk("rst LEDR", {22'b0, LEDR}, 32'h0);
    chk("rst LEDG", {24'b0, LEDG}, 32'h0);
    chk("rst rdValid", {31'b0, rdValid}, 32'h0);
    chk("rst rdData", rdData, 32'h0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Table-driven bus accesses
    for (int i = 0; i < NV; i++) begin
      if (vt[i].wr) begin
        wr(vt[i].a, vt[i].d, s);
      end else begin
        rd(vt[i].a, d, v, s);
        chk($sformatf("vec%0d rdData", i), d, vt[i].rd);
        chk($sformatf("vec%0d rdValid", i), {31'b0, v}, 32'h1);
      end
      chk($sformatf("vec%0d sel", i), {31'b0, s}, {31'b0, vt[i].s});
      chk($sformatf("vec%0d HEX", i), {4'b0, HEX}, {4'b0, vt[i].hex});
      chk($sformatf("vec%0d LEDR", i), {22'b0, LEDR}, {22'b0, vt[i].ledr});
      chk($sformatf("vec%0d LEDG", i), {24'b0, LEDG}, {24'b0, vt[i].ledg});
    end

    // Write and read of the same register in one cycle, then back-to-back reads
    @(negedge clk);
    addr = A_LEDR; wrData = 32'h155; wrEn = 1'b1; rdEn = 1'b1;
    @(posedge clk);
    #1;
    chk("rw_same old data", rdData, 32'h3FF);
    chk("rw_same valid", {31'b0, rdValid}, 32'h1);
    wrEn = 1'b0;
    @(posedge clk);
    #1;
    chk("b2b rd1 LEDR", rdData, 32'h155);
    chk("b2b rd1 valid", {31'b0, rdValid}, 32'h1);
    addr = A_LEDG;
    @(posedge clk);
    #1;
    chk("b2b rd2 LEDG", rdData, 32'h78);
    chk("b2b rd2 valid", {31'b0, rdValid}, 32'h1);
    rdEn = 1'b0;
    @(posedge clk);
    #1;
    chk("b2b valid drop", {31'b0, rdValid}, 32'h0);

    // Short glitch on KEY[2] is filtered
    @(negedge clk);
    KEY[2] = 1'b0;
    repeat (5) @(negedge clk);
    KEY[2] = 1'b1;
    repeat (14) @(negedge clk);
    rd_chk("glitch KEY", A_KEY, 32'h0);
    rd_chk("glitch KSTAT", A_KST, 32'h0);

    // Held press on KEY[2]: poll the KEY register every cycle
    lat = -1;
    @(negedge clk);
    KEY[2] = 1'b0; addr = A_KEY; rdEn = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (rdData[2] === 1'b1) begin
        lat = k - 1;
        break;
      end
    end
    rdEn = 1'b0;
    n_cmp++;
    if (lat < 9 || lat > 11) begin
      n_err++;
      $display("FAIL key_latency: got %0d cycles, want 9..11", lat);
    end
    if (lat < 1) lat = 10;
    rd_chk("press KEY", A_KEY, 32'h4);
    rd_chk("press KSTAT", A_KST, 32'h4);

    // KSTAT write-1-to-clear
    @(negedge clk);
    KEY[1] = 1'b0;
    repeat (14) @(negedge clk);
    rd_chk("kst 0110", A_KST, 32'h6);
    wr(A_KST, 32'h2, s);
    rd_chk("kst w1c bit1", A_KST, 32'h4);
    rd_chk("kst KEY level", A_KEY, 32'h6);
    wr(A_KST, 32'h4, s);
    rd_chk("kst w1c bit2", A_KST, 32'h0);
    @(negedge clk);
    KEY = 4'hF;
    repeat (14) @(negedge clk);
    rd_chk("release KSTAT", A_KST, 32'h0);
    rd_chk("release KEY", A_KEY, 32'h0);

    // W1C aimed at the edge where the new press lands: the press wins
    @(negedge clk);
    KEY[2] = 1'b0;
    repeat (lat - 1) @(negedge clk);
    addr = A_KST; wrData = 32'h4; wrEn = 1'b1;
    @(negedge clk);
    wrEn = 1'b0;
    rd_chk("w1c vs press", A_KST, 32'h4);
    wr(A_KST, 32'h4, s);
    rd_chk("w1c after press", A_KST, 32'h0);
    @(negedge clk);
    KEY = 4'hF;
    repeat (14) @(negedge clk);

    // Switch change interrupted by reset, with a read in flight
    @(negedge clk);
    SW = 10'h155;
    repeat (5) @(negedge clk);
    addr = A_LEDG; rdEn = 1'b1;
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    rdEn = 1'b0;
    #1;
    chk("midrst rdValid", {31'b0, rdValid}, 32'h0);
    chk("midrst rdData", rdData, 32'h0);
    chk("midrst LEDR", {22'b0, LEDR}, 32'h0);
    chk("midrst LEDG", {24'b0, LEDG}, 32'h0);
    chk("midrst HEX", {4'b0, HEX}, {4'b0, H_RST});
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    rd_chk("postrst SW", A_SW, 32'h0);
    rd_chk("postrst KSTAT", A_KST, 32'h0);
    repeat (12) @(negedge clk);
    rd_chk("settled SW", A_SW, 32'h155);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
